// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI master slice.
package spi_pkg;

    // Frame sequencer states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LEAD  = 2'd1,
        ST_SHIFT = 2'd2
    } state_t;

    // SPI modes encoded as {CPOL, CPHA}.
    localparam logic [1:0] MODE0 = 2'b00;
    localparam logic [1:0] MODE1 = 2'b01;
    localparam logic [1:0] MODE2 = 2'b10;
    localparam logic [1:0] MODE3 = 2'b11;

    // Number of cycles busy stays high for one frame.
    function automatic int unsigned busy_cycles(input int unsigned div, input int unsigned width);
        return div * (2 * width + 1);
    endfunction

endpackage

// File: rtl/spi_edge_gen.sv
// SCK prescaler and edge counter: tick every DIV cycles, edge classification while shifting.
module spi_edge_gen
    import spi_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DIV   = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic shift,
    output logic tick_c,
    output logic lead_edge_c,
    output logic trail_edge_c,
    output logic last_edge_c
);

    localparam int unsigned DW = $clog2(DIV + 1);
    localparam int unsigned EW = $clog2(2 * WIDTH + 1);

    logic [DW-1:0] div_cnt_q, div_cnt_d;
    logic [EW-1:0] edge_cnt_q, edge_cnt_d;

    // Tick decode, edge classification and counter next values.
    always_comb begin
        tick_c       = en && (div_cnt_q == DW'(DIV - 1));
        lead_edge_c  = tick_c && shift && !edge_cnt_q[0];
        trail_edge_c = tick_c && shift && edge_cnt_q[0];
        last_edge_c  = trail_edge_c && (edge_cnt_q == EW'(2 * WIDTH - 1));
        div_cnt_d    = '0;
        edge_cnt_d   = '0;
        if (en && !tick_c) begin
            div_cnt_d = div_cnt_q + DW'(1);
        end
        if (shift) begin
            edge_cnt_d = tick_c ? edge_cnt_q + EW'(1) : edge_cnt_q;
        end
    end

    // Counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_cnt_q  <= '0;
            edge_cnt_q <= '0;
        end else begin
            div_cnt_q  <= div_cnt_d;
            edge_cnt_q <= edge_cnt_d;
        end
    end

endmodule

// File: rtl/spi_master.sv
// SPI master: frame FSM, shift register and chip-select decode; CS held until explicit deselect.
module spi_master
    import spi_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DIV   = 1,
    parameter int unsigned CPOL  = 0,
    parameter int unsigned CPHA  = 0,
    parameter int unsigned NCS   = 1,
    localparam int unsigned CSW  = (NCS > 1) ? $clog2(NCS) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             deselect,
    input  logic [CSW-1:0]   cs_sel,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             busy,
    output logic             SCK,
    output logic             SDO,
    input  logic             SDI,
    output logic [NCS-1:0]   CSX
);

    localparam logic SCK_IDLE = 1'(CPOL);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic [NCS-1:0]   csx_q, csx_d;
    logic             rx_q, rx_d;
    logic             sck_q, sck_d;
    logic             sdo_q, sdo_d;
    logic             busy_q, busy_d;

    logic             tick_c, lead_edge_c, trail_edge_c, last_edge_c;
    logic             shift_bit_c;
    logic [WIDTH-1:0] shifted_c;

    spi_edge_gen #(
        .WIDTH (WIDTH),
        .DIV   (DIV)
    ) u_edge (
        .clk          (clk),
        .reset        (reset),
        .en           (state_q != ST_IDLE),
        .shift        (state_q == ST_SHIFT),
        .tick_c       (tick_c),
        .lead_edge_c  (lead_edge_c),
        .trail_edge_c (trail_edge_c),
        .last_edge_c  (last_edge_c)
    );

    // Shift register advanced by one bit; CPHA=1 takes SDI directly on the trailing edge.
    always_comb begin
        shift_bit_c = (CPHA != 0) ? SDI : rx_q;
        shifted_c   = WIDTH'({shreg_q, shift_bit_c});
    end

    // Next-state and datapath logic.
    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        dout_d  = dout_q;
        csx_d   = csx_q;
        rx_d    = rx_q;
        sck_d   = sck_q;
        sdo_d   = sdo_q;
        busy_d  = busy_q;
        unique case (state_q)
            ST_IDLE: begin
                if (load) begin
                    csx_d = '1;
                    if (!deselect) begin
                        for (int unsigned i = 0; i < NCS; i++) begin
                            if (cs_sel == CSW'(i)) csx_d[i] = 1'b0;
                        end
                        shreg_d = din;
                        sdo_d   = (CPHA == 0) ? din[WIDTH-1] : 1'b0;
                        busy_d  = 1'b1;
                        state_d = ST_LEAD;
                    end
                end
            end
            ST_LEAD: begin
                if (tick_c) state_d = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (tick_c) sck_d = ~sck_q;
                if (lead_edge_c) begin
                    if (CPHA == 0) rx_d  = SDI;
                    else           sdo_d = shreg_q[WIDTH-1];
                end
                if (trail_edge_c) begin
                    shreg_d = shifted_c;
                    if (CPHA == 0) sdo_d = shifted_c[WIDTH-1];
                end
                if (last_edge_c) begin
                    dout_d  = shifted_c;
                    sdo_d   = 1'b0;
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            shreg_q <= '0;
            dout_q  <= '0;
            csx_q   <= '1;
            rx_q    <= 1'b0;
            sck_q   <= SCK_IDLE;
            sdo_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            dout_q  <= dout_d;
            csx_q   <= csx_d;
            rx_q    <= rx_d;
            sck_q   <= sck_d;
            sdo_q   <= sdo_d;
            busy_q  <= busy_d;
        end
    end

    assign dout = dout_q;
    assign busy = busy_q;
    assign SCK  = sck_q;
    assign SDO  = sdo_q;
    assign CSX  = csx_q;

endmodule

// File: tb/tb_spi_master.sv
// Randomised bench for spi_master: six instances covering modes, widths, dividers and CS counts.
module tb_spi_master;

    logic        clk = 1'b0;
    logic        reset, load, deselect;
    logic [1:0]  cs_sel;
    logic [15:0] din16;
    int          n_tests = 0;
    int          n_fail  = 0;

    always #5 clk = ~clk;

    // Instance A: 8 bit, DIV=1, mode 0, four chip selects, driven by a slave model.
    logic [7:0] dout_a;
    logic       busy_a, sck_a, sdo_a, sdi_a;
    logic [3:0] csx_a;
    spi_master #(.WIDTH(8), .DIV(1), .CPOL(0), .CPHA(0), .NCS(4)) u_a (
        .clk(clk), .reset(reset), .load(load), .deselect(deselect), .cs_sel(cs_sel),
        .din(din16[7:0]), .dout(dout_a), .busy(busy_a), .SCK(sck_a), .SDO(sdo_a),
        .SDI(sdi_a), .CSX(csx_a));

    // Instances M0..M3: 8 bit, DIV=4, every mode, loopback.
    logic [7:0] dout_m[4];
    logic       busy_m[4], sck_m[4], sdo_m[4], csx_m[4];
    for (genvar m = 0; m < 4; m++) begin : g_mode
        spi_master #(.WIDTH(8), .DIV(4), .CPOL(m / 2), .CPHA(m % 2), .NCS(1)) u (
            .clk(clk), .reset(reset), .load(load), .deselect(deselect), .cs_sel(1'b0),
            .din(din16[7:0]), .dout(dout_m[m]), .busy(busy_m[m]), .SCK(sck_m[m]),
            .SDO(sdo_m[m]), .SDI(sdo_m[m]), .CSX(csx_m[m]));
    end

    // Instance W: 16 bit, DIV=2, mode 3, three chip selects, loopback.
    logic [15:0] dout_w;
    logic        busy_w, sck_w, sdo_w;
    logic [2:0]  csx_w;
    spi_master #(.WIDTH(16), .DIV(2), .CPOL(1), .CPHA(1), .NCS(3)) u_w (
        .clk(clk), .reset(reset), .load(load), .deselect(deselect), .cs_sel(cs_sel),
        .din(din16), .dout(dout_w), .busy(busy_w), .SCK(sck_w), .SDO(sdo_w),
        .SDI(sdo_w), .CSX(csx_w));

    // Slave for A: presents MSB first, advances on each falling SCK (mode 0 trailing edge).
    logic [7:0] slave_word = '0;
    logic [7:0] lead_bits  = '0;
    int         sck_falls  = 0;
    int         sck_rises  = 0;
    int         slave_base = 0;
    assign sdi_a = slave_word[3'(7 - ((sck_falls - slave_base) & 7))];
    always @(negedge sck_a) sck_falls++;
    always @(posedge sck_a) begin
        lead_bits = {lead_bits[6:0], sdo_a};
        sck_rises++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One frame on all instances; optional ignored load (or load+deselect) at cycle mid_at.
    task automatic run_frame(input logic [15:0] d, input logic [1:0] sel, input logic [7:0] sw,
                             input int mid_at, input logic mid_desel);
        int          cnt[6]     = '{default: 0};
        logic        done[6]    = '{default: 1'b0};
        int          exp_busy[6] = '{17, 68, 68, 68, 68, 66};
        logic [15:0] exp_d[6];
        logic        b[6], s[6];
        logic [15:0] dv[6];
        int          run[2]     = '{0, 0};
        int          nruns[2]   = '{0, 0};
        logic        badrun[2]  = '{1'b0, 1'b0};
        logic        sdo_bad    = 1'b0;
        logic        cs_bad     = 1'b0;
        logic        all_done   = 1'b0;
        int          rise_base;
        logic [3:0]  exp_csx_a  = 4'hF & ~(4'b0001 << sel);
        logic [2:0]  exp_csx_w  = (sel < 2'd3) ? (3'h7 & ~(3'b001 << sel)) : 3'h7;
        exp_d[0] = {8'h00, sw};
        for (int i = 1; i < 5; i++) exp_d[i] = {8'h00, d[7:0]};
        exp_d[5] = d;
        din16 = d; cs_sel = sel; slave_word = sw;
        slave_base = sck_falls; rise_base = sck_rises;
        load = 1'b1; deselect = 1'b0;
        @(negedge clk);
        load = 1'b0;
        for (int c = 0; c < 200; c++) begin
            b[0] = busy_a; s[0] = sdo_a; dv[0] = {8'h00, dout_a};
            for (int m = 0; m < 4; m++) begin
                b[m+1] = busy_m[m]; s[m+1] = sdo_m[m]; dv[m+1] = {8'h00, dout_m[m]};
            end
            b[5] = busy_w; s[5] = sdo_w; dv[5] = dout_w;
            all_done = 1'b1;
            for (int i = 0; i < 6; i++) begin
                if (!b[i] && s[i]) sdo_bad = 1'b1;
                if (!done[i]) begin
                    if (b[i]) cnt[i]++;
                    else begin
                        done[i] = 1'b1;
                        check_eq($sformatf("dout_at_fall[%0d]", i), 32'(dv[i]), 32'(exp_d[i]));
                    end
                end
                all_done &= done[i];
            end
            if ($countones(~csx_a) > 1) cs_bad = 1'b1;
            for (int m = 0; m < 2; m++) begin
                if (sck_m[m]) run[m]++;
                else if (run[m] != 0) begin
                    nruns[m]++;
                    if (run[m] != 4) badrun[m] = 1'b1;
                    run[m] = 0;
                end
            end
            if (all_done) break;
            if (c == mid_at) begin
                load = 1'b1; deselect = mid_desel; din16 = 16'h0000; cs_sel = sel + 2'd1;
            end
            if (c == mid_at + 1) begin
                load = 1'b0; deselect = 1'b0;
            end
            @(negedge clk);
        end
        load = 1'b0; deselect = 1'b0;
        check_eq("frame_timeout", 32'(all_done), 32'd1);
        for (int i = 0; i < 6; i++)
            check_eq($sformatf("busy_cycles[%0d]", i), 32'(cnt[i]), 32'(exp_busy[i]));
        check_eq("csx_a", 32'(csx_a), 32'(exp_csx_a));
        check_eq("csx_w", 32'(csx_w), 32'(exp_csx_w));
        check_eq("csx_m0", 32'(csx_m[0]), 32'd0);
        check_eq("lead_edge_count", 32'(sck_rises - rise_base), 32'd8);
        check_eq("sdo_at_lead_edges", 32'(lead_bits), 32'(d[7:0]));
        check_eq("sdo_idle_zero", 32'(sdo_bad), 32'd0);
        check_eq("csx_one_hot_low", 32'(cs_bad), 32'd0);
        check_eq("sck_idle_a", 32'(sck_a), 32'd0);
        for (int m = 0; m < 4; m++)
            check_eq($sformatf("sck_idle_m%0d", m), 32'(sck_m[m]), 32'(m / 2));
        check_eq("sck_idle_w", 32'(sck_w), 32'd1);
        for (int m = 0; m < 2; m++) begin
            check_eq($sformatf("sck_pulses_m%0d", m), 32'(nruns[m]), 32'd8);
            check_eq($sformatf("sck_high_time_m%0d", m), 32'(badrun[m]), 32'd0);
        end
    endtask

    task automatic deselect_all();
        load = 1'b1; deselect = 1'b1;
        @(negedge clk);
        load = 1'b0; deselect = 1'b0;
        check_eq("deselect_csx_a", 32'(csx_a), 32'hF);
        check_eq("deselect_csx_w", 32'(csx_w), 32'h7);
        check_eq("deselect_csx_m0", 32'(csx_m[0]), 32'd1);
        check_eq("deselect_busy_a", 32'(busy_a), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; load = 1'b0; deselect = 1'b0; cs_sel = 2'd0; din16 = 16'h0000;
        repeat (2) @(negedge clk);
        check_eq("rst_busy_a", 32'(busy_a), 32'd0);
        check_eq("rst_csx_a", 32'(csx_a), 32'hF);
        check_eq("rst_sck_a", 32'(sck_a), 32'd0);
        check_eq("rst_sdo_a", 32'(sdo_a), 32'd0);
        check_eq("rst_dout_a", 32'(dout_a), 32'd0);
        check_eq("rst_sck_w", 32'(sck_w), 32'd1);
        check_eq("rst_csx_w", 32'(csx_w), 32'h7);
        check_eq("rst_dout_w", 32'(dout_w), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        run_frame(16'h129F, 2'd0, 8'hEF, -1, 1'b0);
        run_frame(16'h12A5, 2'd2, 8'h3C, -1, 1'b0);
        run_frame(16'h1234, 2'd0, 8'hC3, -1, 1'b0);
        deselect_all();
        run_frame(16'($urandom), 2'd1, 8'($urandom), 5, 1'b0);
        run_frame(16'($urandom), 2'd3, 8'($urandom), 7, 1'b1);
        for (int i = 0; i < 8; i++)
            run_frame(16'($urandom), 2'($urandom_range(0, 3)), 8'($urandom), -1, 1'b0);

        // Reset in the middle of a frame, between clock edges.
        din16 = 16'($urandom); cs_sel = 2'd1; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        repeat (6) @(negedge clk);
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check_eq("midrst_csx_a", 32'(csx_a), 32'hF);
        check_eq("midrst_sck_a", 32'(sck_a), 32'd0);
        check_eq("midrst_busy_a", 32'(busy_a), 32'd0);
        check_eq("midrst_dout_a", 32'(dout_a), 32'd0);
        check_eq("midrst_sdo_a", 32'(sdo_a), 32'd0);
        check_eq("midrst_busy_m3", 32'(busy_m[3]), 32'd0);
        check_eq("midrst_sck_m3", 32'(sck_m[3]), 32'd1);
        check_eq("midrst_dout_w", 32'(dout_w), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        run_frame(16'($urandom), 2'($urandom_range(0, 3)), 8'($urandom), -1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
